ultrasonic_echo_model: RTL and testbench

ULTRASONIC_ECHO_MODEL -- requirements
Module: ultrasonic_echo_model

---
 rtl/ultrasonic_echo_model.sv | 114 +++++++++++
 tb/tb_ultrasonic_echo_model.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/ultrasonic_echo_model.sv
// ultrasonic_echo_model: emulates an HC-SR04 style sensor, answering a trigger pulse with a distance-coded echo pulse
module ultrasonic_echo_model #(
  parameter int CLK_PER_US  = 25,
  parameter int MIN_TRIG_US = 10,
  parameter int BURST_US    = 250,
  parameter int TIMEOUT_US  = 38000,
  parameter int HOLDOFF_US  = 10000
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  input  logic       trig,
  input  logic [8:0] dist_cm,
  input  logic       target_en,
  output logic       echo,
  output logic       busy,
  output logic       err_short
);
  typedef enum logic [2:0] {IDLE, TRIG, BURST, ECHO, HOLDOFF} state_t;
  localparam int PW = (CLK_PER_US > 1) ? $clog2(CLK_PER_US) : 1;
  localparam int B_LAST = BURST_US * CLK_PER_US - 2;
  localparam logic [15:0] B_US = 16'(B_LAST / CLK_PER_US);
  localparam logic [PW-1:0] B_PRE = PW'(B_LAST % CLK_PER_US);
  localparam logic [PW-1:0] PRE_TC = PW'(CLK_PER_US - 1);
  localparam logic [15:0] TIMEOUT_W = 16'(TIMEOUT_US);
  localparam logic [15:0] HOLD_LAST = 16'(HOLDOFF_US - 1);
  localparam logic [16:0] MIN_W = 17'(MIN_TRIG_US);
  state_t state, next_state;
  logic trig_m, trig_s, trig_s_d;
  logic [2:0] vld;
  logic [PW-1:0] pre;
  logic [15:0] us_cnt;
  logic [8:0] dist_l;
  logic tgt_l;
  logic trig_rise, us_tick, trig_ok, tgt_ok;
  logic [16:0] trig_us;
  logic [14:0] dist_w;
  logic [15:0] echo_w;
  logic echo_d, busy_d, err_d;
  // Two-flop synchronizer plus a fill marker so a trigger already high at reset release is not seen as an edge
  always_ff @(posedge sys_clk or negedge sys_rst_n)
    if (!sys_rst_n) begin
      trig_m <= 1'b0;
      trig_s <= 1'b0;
      trig_s_d <= 1'b0;
      vld <= '0;
    end else begin
      trig_m <= trig;
      trig_s <= trig_m;
      trig_s_d <= trig_s;
      vld <= {vld[1:0], 1'b1};
    end
  assign trig_rise = vld[2] & trig_s & ~trig_s_d;
  assign us_tick = pre == PRE_TC;
  // The fall-detection cycle still belongs to the high period, so its tick counts toward the trigger width
  assign trig_us = {1'b0, us_cnt} + 17'(us_tick);
  assign trig_ok = trig_us >= MIN_W;
  assign tgt_ok = tgt_l && dist_l != 9'd0 && dist_l <= 9'd400;
  assign dist_w = {6'd0, dist_l} * 15'd58;
  assign echo_w = tgt_ok ? {1'b0, dist_w} : TIMEOUT_W;
  // State register
  always_ff @(posedge sys_clk or negedge sys_rst_n)
    if (!sys_rst_n) state <= IDLE;
    else state <= next_state;
  // Next-state logic; BURST ends one cycle early because echo is registered from next_state
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    next_state = trig_rise ? TRIG : IDLE;
      TRIG:    next_state = trig_s ? TRIG : (trig_ok ? BURST : IDLE);
      BURST:   next_state = (us_cnt == B_US && pre == B_PRE) ? ECHO : BURST;
      ECHO:    next_state = (us_tick && us_cnt == echo_w - 16'd1) ? HOLDOFF : ECHO;
      HOLDOFF: next_state = (us_tick && us_cnt == HOLD_LAST) ? IDLE : HOLDOFF;
      default: next_state = IDLE;
    endcase
  end
  // Microsecond prescaler and saturating microsecond counter, restarted on every state entry
  always_ff @(posedge sys_clk or negedge sys_rst_n)
    if (!sys_rst_n) begin
      pre <= '0;
      us_cnt <= '0;
    end else if (next_state != state || state == IDLE) begin
      pre <= '0;
      us_cnt <= '0;
    end else begin
      pre <= us_tick ? '0 : pre + PW'(1);
      us_cnt <= (us_tick && us_cnt != 16'hFFFF) ? us_cnt + 16'd1 : us_cnt;
    end
  // Capture the target description once the trigger is accepted
  always_ff @(posedge sys_clk or negedge sys_rst_n)
    if (!sys_rst_n) begin
      dist_l <= '0;
      tgt_l <= 1'b0;
    end else if (state == TRIG && next_state == BURST) begin
      dist_l <= dist_cm;
      tgt_l <= target_en;
    end
  // Output decode, looking one state ahead so the registered outputs line up with the state
  always_comb begin
    echo_d = next_state == ECHO;
    busy_d = next_state != IDLE;
    err_d = state == TRIG && !trig_s && !trig_ok;
  end
  // Registered outputs keep echo and err_short glitch-free
  always_ff @(posedge sys_clk or negedge sys_rst_n)
    if (!sys_rst_n) begin
      echo <= 1'b0;
      busy <= 1'b0;
      err_short <= 1'b0;
    end else begin
      echo <= echo_d;
      busy <= busy_d;
      err_short <= err_d;
    end
endmodule

// File: tb/tb_ultrasonic_echo_model.sv
// tb_ultrasonic_echo_model: randomized and directed checks of echo timing against a behavioural reference
module tb_ultrasonic_echo_model;
  localparam int C = 2;
  localparam int MIN = 4;
  localparam int BUS = 6;
  localparam int TO = 300;
  localparam int HO = 20;
  localparam int B = BUS * C;
  logic sys_clk = 1'b0;
  logic sys_rst_n = 1'b0;
  logic trig = 1'b0;
  logic target_en = 1'b0;
  logic [8:0] dist_cm = '0;
  logic echo, busy, err_short;
  int checks = 0;
  int failures = 0;
  ultrasonic_echo_model #(
    .CLK_PER_US(C), .MIN_TRIG_US(MIN), .BURST_US(BUS), .TIMEOUT_US(TO), .HOLDOFF_US(HO)
  ) dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .trig(trig), .dist_cm(dist_cm),
    .target_en(target_en), .echo(echo), .busy(busy), .err_short(err_short)
  );
  always #5 sys_clk = ~sys_clk;
  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask
  function automatic int ref_width(input int d, input bit en);
    return (en && d >= 1 && d <= 400) ? d * 58 : TO;
  endfunction
  // mode 0: plain, 1: disturb inputs during burst/echo/holdoff, 2: hold trig high across holdoff exit
  task automatic meas(input int n, input int d, input bit en, input int mode);
    int w, len, rise_idx, fall_idx, blow_idx, hi, rises, errs, err_idx, again, toff;
    bit acc;
    logic prev_echo;
    acc = (n / C) >= MIN;
    w = ref_width(d, en);
    len = acc ? B + 2 + w * C + HO * C + 30 : 30;
    dist_cm = 9'(d);
    target_en = en;
    @(negedge sys_clk);
    trig = 1'b1;
    repeat (n) @(negedge sys_clk);
    trig = 1'b0;
    check("busy_in_trig", busy, 1);
    rise_idx = -1; fall_idx = -1; blow_idx = -1; err_idx = -1; toff = -1;
    hi = 0; rises = 0; errs = 0; again = 0; prev_echo = 1'b0;
    for (int idx = 1; idx <= len; idx++) begin
      @(negedge sys_clk);
      if (echo && !prev_echo) begin
        rises++;
        if (rise_idx < 0) rise_idx = idx;
      end
      if (!echo && prev_echo && fall_idx < 0) fall_idx = idx;
      prev_echo = echo;
      if (echo) hi++;
      if (err_short) begin
        errs++;
        if (err_idx < 0) err_idx = idx;
      end
      if (blow_idx >= 0 && busy) again++;
      if (blow_idx < 0 && !busy && (!acc || fall_idx >= 0)) blow_idx = idx;
      if (mode == 1 && idx == 5) begin
        dist_cm = 9'(d + 3);
        target_en = ~en;
      end
      if (mode == 1 && ((echo && hi == 10) || (fall_idx >= 0 && idx == fall_idx + 5))) begin
        trig = 1'b1;
        toff = idx + 15;
      end
      if (idx == toff) trig = 1'b0;
      if (mode == 2 && fall_idx >= 0 && idx == fall_idx + 10) trig = 1'b1;
    end
    trig = 1'b0;
    if (acc) begin
      check("echo_rise_delay", rise_idx, B + 2);
      check("echo_width", hi, w * C);
      check("busy_release", blow_idx - fall_idx, HO * C);
      check("echo_count", rises, 1);
      check("no_err_short", errs, 0);
      check("busy_stays_low", again, 0);
    end else begin
      check("err_pulses", errs, 1);
      check("err_timing", err_idx, 3);
      check("no_echo_on_short", rises, 0);
      check("busy_low_after_err", blow_idx, 3);
    end
    repeat (5) @(negedge sys_clk);
  endtask
  initial begin
    int hi_cnt;
    repeat (3) @(negedge sys_clk);
    check("rst_echo", echo, 0);
    check("rst_busy", busy, 0);
    check("rst_err", err_short, 0);
    sys_rst_n = 1'b1;
    repeat (5) @(negedge sys_clk);
    meas(8, 10, 1'b1, 0);
    meas(7, 10, 1'b1, 0);
    meas(3, 10, 1'b1, 0);
    meas(9, 3, 1'b1, 0);
    meas(12, 0, 1'b1, 0);
    meas(12, 401, 1'b1, 0);
    meas(12, 20, 1'b0, 0);
    meas(12, 400, 1'b1, 0);
    meas(10, 7, 1'b1, 1);
    meas(10, 4, 1'b1, 2);
    dist_cm = 9'd5;
    target_en = 1'b1;
    @(negedge sys_clk);
    trig = 1'b1;
    repeat (10) @(negedge sys_clk);
    trig = 1'b0;
    repeat (B + 22) @(negedge sys_clk);
    check("echo_before_reset", echo, 1);
    trig = 1'b1;
    #2 sys_rst_n = 1'b0;
    #1;
    check("reset_drops_echo", echo, 0);
    check("reset_drops_busy", busy, 0);
    @(negedge sys_clk);
    sys_rst_n = 1'b1;
    hi_cnt = 0;
    repeat (40) begin
      @(negedge sys_clk);
      if (echo || busy) hi_cnt++;
    end
    check("no_start_after_reset", hi_cnt, 0);
    trig = 1'b0;
    repeat (5) @(negedge sys_clk);
    meas(10, 2, 1'b1, 0);
    for (int i = 0; i < 10; i++) begin
      int n, d;
      bit en;
      n = $urandom_range(14, 3);
      d = ($urandom % 5 == 0) ? $urandom_range(511, 401) : $urandom_range(12, 0);
      en = ($urandom % 4) != 0;
      meas(n, d, en, ($urandom % 3 == 0) ? 1 : 0);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
